mandel_engine_param: RTL and testbench

//  Parametrised Mandelbrot iteration engine; next generation of the per-pixel calc engine.
//  The coordinate generator assigns work to each engine over a shared addressed bus.

---
 rtl/mandel_engine_param.sv | 135 +++++++++++++
 tb/tb_mandel_engine_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mandel_engine_param.sv
// mandel_engine_param: parametrised Mandelbrot iteration engine with addressed work assignment and tri-state result bus.
// Optional Julia mode is enabled by defining MANDEL_JULIA_EN (adds julia_sel / julia_c inputs).
module mandel_engine_param #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 24,
  parameter int ITER_W     = 16,
  parameter int OUT_ITER_W = 8,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
) (
  input  logic                            Engine_CLK,
  input  logic                            eRST,
  input  logic [ADDR_W-1:0]               my_addr,
  input  logic [ADDR_W-1:0]               engine_addr,
  input  logic                            latch_en,
  input  logic [X_W+Y_W+2*DATA_W-1:0]     in_word,
  input  logic [ITER_W-1:0]               max_iter,
`ifdef MANDEL_JULIA_EN
  input  logic                            julia_sel,
  input  logic [2*DATA_W-1:0]             julia_c,
`endif
  input  logic                            req_ack,
  output logic [X_W+Y_W+OUT_ITER_W:0]     out_word,
  output logic                            available,
  output logic                            service_req
);
  localparam int PW = 2 * DATA_W;
  localparam int W2 = PW + 1;
  localparam int NW = DATA_W + 2;
  localparam logic signed [W2-1:0] esc_lim = W2'(4) << FRAC_W;
  typedef enum logic [2:0] {IDLE, MULT, ADD, DONE, ACK} state_t;
  state_t state;
  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;
  logic signed [DATA_W-1:0] c_re, c_im, z_re, z_im, in_re, in_im;
  logic signed [PW-1:0] rr, ii, ri;
  logic [ITER_W-1:0] iter, max_r, iter_inc;
  logic escaped, hit, fits, go;
  logic signed [W2-1:0] mag, diff;
  logic signed [NW-1:0] n_re, n_im;
  logic [OUT_ITER_W-1:0] sat;
  assign in_re = in_word[DATA_W +: DATA_W];
  assign in_im = in_word[0 +: DATA_W];
  assign go = latch_en && engine_addr == my_addr;
  // Escape test is done at full product width so a large z can never wrap into a false "bounded"
  always_comb begin
    mag = W2'(rr) + W2'(ii);
    diff = W2'(rr) - W2'(ii);
    hit = (mag >>> FRAC_W) > esc_lim;
    n_re = NW'(diff >>> FRAC_W) + NW'(c_re);
    n_im = NW'(ri >>> (FRAC_W - 1)) + NW'(c_im);
    fits = (n_re[NW-1:DATA_W-1] == '0 || n_re[NW-1:DATA_W-1] == '1) &&
           (n_im[NW-1:DATA_W-1] == '0 || n_im[NW-1:DATA_W-1] == '1);
    iter_inc = iter + ITER_W'(1);
    sat = |iter[ITER_W-1:OUT_ITER_W] ? '1 : iter[OUT_ITER_W-1:0];
  end
  // Result is visible on the shared bus only while granted and holding a finished pixel
  assign out_word = (req_ack && (state == DONE || state == ACK)) ? {x_r, y_r, escaped, sat} : 'z;
  // Engine control: assignment, two-clock multiply/add iteration, result handshake
  always_ff @(posedge Engine_CLK or posedge eRST) begin
    if (eRST) begin
      state <= IDLE;
      available <= 1'b1;
      service_req <= 1'b0;
      x_r <= '0;
      y_r <= '0;
      c_re <= '0;
      c_im <= '0;
      z_re <= '0;
      z_im <= '0;
      rr <= '0;
      ii <= '0;
      ri <= '0;
      iter <= '0;
      max_r <= '0;
      escaped <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          x_r <= in_word[X_W+Y_W+PW-1 -: X_W];
          y_r <= in_word[PW +: Y_W];
`ifdef MANDEL_JULIA_EN
          z_re <= julia_sel ? in_re : '0;
          z_im <= julia_sel ? in_im : '0;
          c_re <= julia_sel ? julia_c[PW-1 -: DATA_W] : in_re;
          c_im <= julia_sel ? julia_c[DATA_W-1:0] : in_im;
`else
          z_re <= '0;
          z_im <= '0;
          c_re <= in_re;
          c_im <= in_im;
`endif
          max_r <= max_iter;
          iter <= '0;
          escaped <= 1'b0;
          available <= 1'b0;
          service_req <= max_iter == '0;
          state <= max_iter == '0 ? DONE : MULT;
        end
        MULT: begin
          rr <= PW'(z_re) * PW'(z_re);
          ii <= PW'(z_im) * PW'(z_im);
          ri <= PW'(z_re) * PW'(z_im);
          state <= ADD;
        end
        ADD: if (hit) begin
          escaped <= 1'b1;
          service_req <= 1'b1;
          state <= DONE;
        end else if (!fits) begin
          escaped <= 1'b1;
          iter <= iter_inc;
          service_req <= 1'b1;
          state <= DONE;
        end else begin
          z_re <= DATA_W'(n_re);
          z_im <= DATA_W'(n_im);
          iter <= iter_inc;
          service_req <= iter_inc == max_r;
          state <= iter_inc == max_r ? DONE : MULT;
        end
        DONE: if (req_ack) begin
          service_req <= 1'b0;
          state <= ACK;
        end
        ACK: if (!(req_ack || latch_en)) begin
          available <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_engine_param.sv
// tb_mandel_engine_param: random and directed pixel jobs checked against an exact-arithmetic escape-time model.
module tb_mandel_engine_param;
  localparam int OW = 10 + 9 + 1 + 8;
  logic Engine_CLK = 1'b0;
  logic eRST = 1'b1;
  logic [3:0] my_addr = 4'd5;
  logic [3:0] engine_addr = 4'd0;
  logic latch_en = 1'b0;
  logic [82:0] in_word = '0;
  logic [15:0] max_iter = '0;
  logic req_ack = 1'b0;
  wire [OW-1:0] out_word;
  logic available, service_req;
  logic [OW-1:0] zword = 'z;
`ifdef MANDEL_JULIA_EN
  logic julia_sel = 1'b0;
  logic [63:0] julia_c = '0;
`endif
  int errors = 0;
  int checks = 0;

  mandel_engine_param dut (
    .Engine_CLK(Engine_CLK),
    .eRST(eRST),
    .my_addr(my_addr),
    .engine_addr(engine_addr),
    .latch_en(latch_en),
    .in_word(in_word),
    .max_iter(max_iter),
`ifdef MANDEL_JULIA_EN
    .julia_sel(julia_sel),
    .julia_c(julia_c),
`endif
    .req_ack(req_ack),
    .out_word(out_word),
    .available(available),
    .service_req(service_req)
  );

  always #5 Engine_CLK = ~Engine_CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Escape-time iteration in exact wide integers; also yields clocks from latch to result
  function automatic void model(input logic signed [31:0] zr0, zi0, cr, ci, input int mi,
                                output int it, output bit esc, output int lat);
    logic signed [127:0] zr, zi, rr, ii, ri, nr, ni;
    zr = zr0;
    zi = zi0;
    it = 0;
    esc = 0;
    lat = 0;
    if (mi == 0) return;
    while (1) begin
      rr = zr * zr;
      ii = zi * zi;
      ri = zr * zi;
      if (((rr + ii) >>> 24) > (128'sd4 <<< 24)) begin
        esc = 1;
        lat = 2 * (it + 1);
        return;
      end
      nr = ((rr - ii) >>> 24) + cr;
      ni = (ri >>> 23) + ci;
      it++;
      lat = 2 * it;
      if (nr > 128'sd2147483647 || nr < -128'sd2147483648 ||
          ni > 128'sd2147483647 || ni < -128'sd2147483648) begin
        esc = 1;
        return;
      end
      zr = nr;
      zi = ni;
      if (it == mi) return;
    end
  endfunction

  task automatic job(input logic [9:0] x, input logic [8:0] y, input logic signed [31:0] cr, ci,
                     input int mi, input bit jsel, input logic signed [31:0] jr, ji,
                     input bit stray, input int hold);
    int it, lat, n;
    bit esc;
    logic [7:0] s;
    logic [OW-1:0] exp;
    if (jsel) model(cr, ci, jr, ji, mi, it, esc, lat);
    else model(32'sd0, 32'sd0, cr, ci, mi, it, esc, lat);
    s = it > 255 ? 8'hFF : it[7:0];
    exp = {x, y, esc, s};
    @(negedge Engine_CLK);
    in_word = {x, y, cr, ci};
    max_iter = mi[15:0];
    engine_addr = my_addr;
`ifdef MANDEL_JULIA_EN
    julia_sel = jsel;
    julia_c = {jr, ji};
`endif
    latch_en = 1'b1;
    @(posedge Engine_CLK);
    #1;
    latch_en = 1'b0;
    in_word = ~in_word;
    max_iter = 16'd1;
    chk("avail_busy", available, 0);
    n = 0;
    while (!service_req && n < 1000) begin
      latch_en = stray && n < 2;
      @(posedge Engine_CLK);
      #1;
      n++;
    end
    latch_en = 1'b0;
    chk("latency", n, lat);
    chk("bus_z_before_ack", out_word, zword);
    req_ack = 1'b1;
    #1;
    chk("out_word", out_word, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge Engine_CLK);
      #1;
      chk("svc_cleared", service_req, 0);
      chk("avail_in_ack", available, 0);
      chk("bus_held", out_word, exp);
    end
    req_ack = 1'b0;
    #1;
    chk("bus_released", out_word, zword);
    @(posedge Engine_CLK);
    #1;
    chk("avail_free", available, 1);
  endtask

  initial begin
    logic signed [31:0] cr, ci;
    req_ack = 1'b1;
    repeat (2) @(posedge Engine_CLK);
    #1;
    chk("rst_avail", available, 1);
    chk("rst_svc", service_req, 0);
    chk("rst_bus", out_word, zword);
    @(negedge Engine_CLK);
    eRST = 1'b0;
    req_ack = 1'b0;
    @(negedge Engine_CLK);
    engine_addr = my_addr + 4'd1;
    latch_en = 1'b1;
    @(posedge Engine_CLK);
    #1;
    latch_en = 1'b0;
    chk("wrong_addr_avail", available, 1);
    chk("wrong_addr_svc", service_req, 0);
    job(10'd1, 9'd2, 32'sd0, 32'sd0, 255, 0, 0, 0, 0, 1);
    job(10'd3, 9'd4, 32'sh0300_0000, 32'sd0, 255, 0, 0, 0, 1, 2);
    job(10'd5, 9'd6, 32'sh0100_0000, 32'sd0, 0, 0, 0, 0, 0, 1);
    job(10'd1023, 9'd511, 32'sd0, 32'sd0, 300, 0, 0, 0, 0, 3);
    job(10'd7, 9'd8, -32'sh0200_0000, 32'sd0, 20, 0, 0, 0, 1, 1);
    for (int k = 0; k < 24; k++) begin
      cr = 32'($urandom_range(0, 32'h0500_0000)) - 32'sh0280_0000;
      ci = 32'($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000;
      job(10'($urandom), 9'($urandom), cr, ci, int'($urandom_range(0, 60)), 0, 0, 0,
          bit'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end
`ifdef MANDEL_JULIA_EN
    job(10'd9, 9'd9, 32'sh0080_0000, 32'sd0, 50, 1, 32'sd0, 32'sd0, 0, 1);
    job(10'd9, 9'd10, 32'sh0180_0000, 32'sd0, 50, 1, 32'sd0, 32'sd0, 0, 1);
    job(10'd9, 9'd11, 32'sh0100_0000, 32'sd0, 50, 1, 32'sh7F00_0000, 32'sd0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      cr = 32'($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000;
      ci = 32'($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000;
      job(10'($urandom), 9'($urandom), cr, ci, int'($urandom_range(1, 40)), 1,
          32'($urandom_range(0, 32'h0200_0000)) - 32'sh0100_0000, 32'sh0040_0000, 0, 1);
    end
    julia_sel = 1'b0;
`endif
    @(negedge Engine_CLK);
    in_word = '0;
    max_iter = 16'd255;
    engine_addr = my_addr;
    latch_en = 1'b1;
    @(posedge Engine_CLK);
    #1;
    latch_en = 1'b0;
    repeat (6) @(posedge Engine_CLK);
    #1;
    req_ack = 1'b1;
    #1;
    chk("ack_while_busy_bus", out_word, zword);
    chk("ack_while_busy_svc", service_req, 0);
    @(posedge Engine_CLK);
    #1;
    eRST = 1'b1;
    #1;
    chk("midrst_avail", available, 1);
    chk("midrst_svc", service_req, 0);
    chk("midrst_bus", out_word, zword);
    @(negedge Engine_CLK);
    eRST = 1'b0;
    req_ack = 1'b0;
    job(10'd12, 9'd13, 32'sh0300_0000, 32'sh0100_0000, 10, 0, 0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
